z80_bus_responder: RTL

Synchronous bus-side responder for the tv80s Z80 core. It sits between the CPU pins and a simple req/ack backend, and turns CPU memory and I/O cycles into single backend transactions. It drives `wait_n` to stretch CPU cycles until the backend completes and any programmed wait states expire. It returns `di` for reads and a fixed vector for interrupt-acknowledge cycles. It ignores refresh cycles.

---
 rtl/z80_bus_responder.sv | 122 ++++++++++++
 1 files changed

// File: rtl/z80_bus_responder.sv
// Bus-side responder for the tv80s core: turns CPU memory/IO cycles into one
// req/ack backend transaction each, stretching the CPU with wait_n meanwhile.
module z80_bus_responder #(
    parameter int unsigned MEM_WAIT    = 0,
    parameter int unsigned M1_WAIT     = 1,
    parameter int unsigned IO_WAIT     = 1,
    parameter logic [7:0]  INTA_VECTOR = 8'hFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m1_n,
    input  logic        mreq_n,
    input  logic        iorq_n,
    input  logic        rd_n,
    input  logic        wr_n,
    input  logic        rfsh_n,
    input  logic [15:0] A,
    input  logic [7:0]  dout,
    output logic [7:0]  di,
    output logic        wait_n,
    output logic        be_req,
    output logic        be_we,
    output logic        be_io,
    output logic [15:0] be_addr,
    output logic [7:0]  be_wdata,
    input  logic        be_ack,
    input  logic [7:0]  be_rdata
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    // The exit test sees the counter before its decrement, so a wait of W
    // loads W-1 and yields W ACCESS cycles (a wait of 0 still needs one).
    function automatic logic [3:0] wait_load(input int unsigned w);
        int unsigned s;
        s = (w > 15) ? 15 : w;
        return (s == 0) ? 4'd0 : 4'(s - 1);
    endfunction

    localparam logic [3:0] MEM_LOAD = wait_load(MEM_WAIT);
    localparam logic [3:0] M1_LOAD  = wait_load(M1_WAIT);
    localparam logic [3:0] IO_LOAD  = wait_load(IO_WAIT);

    logic [1:0] state;
    logic [3:0] cnt;
    logic       ack_seen;
    logic       hold_io;
    logic       rw;
    logic       cyc_inta;
    logic       cyc_io;
    logic       cyc_mem;
    logic       ack;
    logic       released;

    always_comb begin
        rw       = !rd_n || !wr_n;
        cyc_inta = !iorq_n && !m1_n;
        cyc_io   = !iorq_n && m1_n && rw;
        cyc_mem  = !mreq_n && rfsh_n && rw && !cyc_inta && !cyc_io;
        ack      = be_ack && be_req;
        released = rd_n && wr_n && (hold_io ? iorq_n : mreq_n);
        wait_n   = !((state == ST_ACCESS) ||
                     ((state == ST_IDLE) && (cyc_io || cyc_mem)));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            cnt      <= 4'd0;
            ack_seen <= 1'b0;
            hold_io  <= 1'b0;
            di       <= 8'h00;
            be_req   <= 1'b0;
            be_we    <= 1'b0;
            be_io    <= 1'b0;
            be_addr  <= 16'h0000;
            be_wdata <= 8'h00;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cyc_inta) begin
                        di      <= INTA_VECTOR;
                        cnt     <= 4'd0;
                        hold_io <= 1'b1;
                        state   <= ST_DONE;
                    end else if (cyc_io || cyc_mem) begin
                        be_addr  <= A;
                        be_wdata <= dout;
                        be_we    <= !wr_n;
                        be_io    <= cyc_io;
                        hold_io  <= cyc_io;
                        cnt      <= cyc_io ? IO_LOAD : (!m1_n ? M1_LOAD : MEM_LOAD);
                        ack_seen <= 1'b0;
                        be_req   <= 1'b1;
                        state    <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (cnt != 4'd0)
                        cnt <= cnt - 4'd1;
                    if (ack) begin
                        be_req   <= 1'b0;
                        ack_seen <= 1'b1;
                        // Read data is dropped if the CPU abandoned the cycle.
                        if (!be_we && !rd_n)
                            di <= be_rdata;
                    end
                    if ((ack_seen || ack) && cnt == 4'd0)
                        state <= ST_DONE;
                end
                ST_DONE: begin
                    if (released)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
